// File: rtl/axi_pkg.sv
// axi_pkg: burst/response codes and channel state types shared by axi_burst_mem
package axi_pkg;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next-beat address and illegal-burst detection for one channel
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] nxt,
    output logic              bad
);
    logic              wrap_ok;
    logic [ADDR_W-1:0] m;
    always_comb begin
        wrap_ok = len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
        m       = ADDR_W'(len);
        bad     = burst == 2'b11 || (burst == WRAP && !wrap_ok);
        // illegal bursts fall through to INCR stepping
        nxt     = burst == FIXED ? addr :
                  (burst == WRAP && wrap_ok) ? (addr & ~m) | ((addr + 1'b1) & m) :
                  addr + 1'b1;
    end
endmodule

// File: rtl/axi_burst_mem.sv
// axi_burst_mem: burst memory slave with concurrent write and read channels
module axi_burst_mem
    import axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [1:0]        awburst,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [1:0]        arburst,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    w_state_t          ws, ws_n;
    r_state_t          rs, rs_n;
    logic [ADDR_W-1:0] waddr, raddr, w_nxt, r_nxt, rb;
    logic [7:0]        wlen, wcnt, rlen, rcnt;
    logic [1:0]        wburst, rburst;
    logic              werr, w_bad, r_bad, w_err_now;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, w_in, rb_in, w_fin;

    // in IDLE the address units see the incoming request so its legality is known at the handshake
    axi_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
        .addr  (ws == W_IDLE ? awaddr : waddr),
        .len   (ws == W_IDLE ? awlen : wlen),
        .burst (ws == W_IDLE ? awburst : wburst),
        .nxt   (w_nxt),
        .bad   (w_bad)
    );

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
        .addr  (rs == R_IDLE ? araddr : raddr),
        .len   (rs == R_IDLE ? arlen : rlen),
        .burst (rs == R_IDLE ? arburst : rburst),
        .nxt   (r_nxt),
        .bad   (r_bad)
    );

    always_comb begin
        aw_hs     = awvalid && awready;
        w_hs      = wvalid && wready;
        b_hs      = bvalid && bready;
        ar_hs     = arvalid && arready;
        r_hs      = rvalid && rready;
        w_fin     = wcnt == wlen;
        w_in      = {1'b0, waddr} < LIM;
        w_err_now = werr || !w_in || (wlast != w_fin);
        rb        = ar_hs ? araddr : r_nxt;
        rb_in     = {1'b0, rb} < LIM;
        ws_n      = aw_hs ? W_DATA : (w_hs && w_fin) ? W_RESP : b_hs ? W_IDLE : ws;
        rs_n      = ar_hs ? R_DATA : (r_hs && rlast) ? R_IDLE : rs;
    end

    always_ff @(posedge aclk) begin
        if (!reset) begin
            ws      <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
        end else begin
            ws      <= ws_n;
            awready <= ws_n == W_IDLE;
            wready  <= ws_n == W_DATA;
            bvalid  <= ws_n == W_RESP;
            if (aw_hs) begin
                waddr  <= awaddr;
                wlen   <= awlen;
                wburst <= awburst;
                wcnt   <= '0;
                werr   <= w_bad;
            end
            if (w_hs) begin
                waddr <= w_nxt;
                wcnt  <= wcnt + 8'd1;
                werr  <= w_err_now;
                if (w_fin) bresp <= w_err_now ? SLVERR : OKAY;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset && w_hs && w_in) mem[waddr[IW-1:0]] <= wdata;
    end

    // rdata is sampled from mem at the edge, so a same-cycle write is seen only by later beats
    always_ff @(posedge aclk) begin
        if (!reset) begin
            rs      <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= OKAY;
            rlast   <= 1'b0;
        end else begin
            rs      <= rs_n;
            arready <= rs_n == R_IDLE;
            rvalid  <= rs_n == R_DATA;
            if (ar_hs) begin
                rlen   <= arlen;
                rburst <= arburst;
            end
            if (ar_hs || (r_hs && !rlast)) begin
                raddr <= rb;
                rdata <= rb_in ? mem[rb[IW-1:0]] : '0;
                rresp <= (!rb_in || r_bad) ? SLVERR : OKAY;
                rlast <= ar_hs ? arlen == 8'd0 : rcnt + 8'd1 == rlen;
                rcnt  <= ar_hs ? 8'd0 : rcnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_mem.sv
// tb_axi_burst_mem: randomized scoreboard bench for axi_burst_mem against a behavioural memory model
module tb_axi_burst_mem;
    localparam int DEPTH = 32;
    localparam logic [1:0] OK_R  = 2'b00;
    localparam logic [1:0] ERR_R = 2'b10;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } rbeat_t;

    logic        aclk, reset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [7:0]  awaddr, awlen, araddr, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [31:0] wdata, rdata;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd[$];
    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    int          checks = 0, errors = 0;
    int          r_stall = 0, b_stall = 0;
    bit          rnd = 0;

    axi_burst_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit bad(input int len, input int bt);
        return bt == 3 || (bt == 2 && !(len inside {1, 3, 7, 15}));
    endfunction

    // wrap arithmetic via modulo within an aligned window of len+1 words
    function automatic int nxt(input int a, input int len, input int bt);
        int base;
        if (bt == 0) return a;
        if (bt == 2 && !bad(len, bt)) begin
            base = a - a % (len + 1);
            return base + (a + 1 - base) % (len + 1);
        end
        return (a + 1) % 256;
    endfunction

    task automatic hs(input int k, input string nm);
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (!(k == 0 ? awready : k == 1 ? wready : arready) && t < 500);
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready not seen within %0d cycles", nm, t);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input int a, input int len, input int bt, input int lastb);
        int ad = a;
        bit err = bad(len, bt);
        for (int i = 0; i <= len; i++) begin
            if (ad >= DEPTH) err = 1;
            else ref_mem[ad] = wd[i];
            if ((i == lastb) != (i == len)) err = 1;
            ad = nxt(ad, len, bt);
        end
        bq.push_back(err ? ERR_R : OK_R);
        awvalid = 1;
        awaddr  = a[7:0];
        awlen   = len[7:0];
        awburst = bt[1:0];
        hs(0, "aw");
        awvalid = 0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
            wvalid = 1;
            wdata  = wd[i];
            wlast  = i == lastb;
            hs(1, "w");
            wvalid = 0;
            wlast  = 0;
        end
    endtask

    task automatic rd(input int a, input int len, input int bt);
        int ad = a;
        rbeat_t e;
        for (int i = 0; i <= len; i++) begin
            e.d = ad < DEPTH ? ref_mem[ad] : 32'd0;
            e.r = (ad >= DEPTH || bad(len, bt)) ? ERR_R : OK_R;
            e.l = i == len;
            rq.push_back(e);
            ad = nxt(ad, len, bt);
        end
        arvalid = 1;
        araddr  = a[7:0];
        arlen   = len[7:0];
        arburst = bt[1:0];
        hs(2, "ar");
        arvalid = 0;
    endtask

    task automatic fill(input int n, input int base);
        wd.delete();
        for (int i = 0; i < n; i++) wd.push_back(base < 0 ? $urandom : 32'(base + i));
    endtask

    task automatic drain();
        int t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d read beats and %0d responses outstanding", rq.size(), bq.size());
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (r_stall > 0) begin
                rready = 0;
                if (rvalid) r_stall--;
            end else rready = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
            if (b_stall > 0) begin
                bready = 0;
                if (bvalid) b_stall--;
            end else bready = rnd ? $urandom_range(0, 2) != 0 : 1'b1;
        end
    end

    bit          rs_p = 0, bs_p = 0;
    logic [34:0] prev_r;
    logic [1:0]  prev_b;
    rbeat_t      me;
    logic [1:0]  mb;

    always @(negedge aclk) begin
        if (!reset) begin
            rs_p = 0;
            bs_p = 0;
        end else begin
            if (rs_p) chk("r_hold", {rvalid, rdata, rresp, rlast}, {1'b1, prev_r});
            if (bs_p) chk("b_hold", {bvalid, bresp}, {1'b1, prev_b});
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: beat %0h with none expected", rdata);
                end else begin
                    me = rq.pop_front();
                    chk("rdata", rdata, me.d);
                    chk("rresp", rresp, me.r);
                    chk("rlast", rlast, me.l);
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: bresp %0h with none expected", bresp);
                end else begin
                    mb = bq.pop_front();
                    chk("bresp", bresp, mb);
                end
            end
            rs_p   = rvalid && !rready;
            prev_r = {rdata, rresp, rlast};
            bs_p   = bvalid && !bready;
            prev_b = bresp;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, len, bt, lb;
        reset = 0; awvalid = 0; wvalid = 0; arvalid = 0; wlast = 0;
        awaddr = 0; awlen = 0; awburst = 0; araddr = 0; arlen = 0; arburst = 0; wdata = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_outs", {awready, wready, bvalid, bresp, arready, rvalid, rresp, rlast, rdata}, 0);
        @(posedge aclk);
        #1 reset = 1;
        @(posedge aclk);
        @(negedge aclk);
        chk("ready_after_release", {awready, arready}, 2'b11);
        @(posedge aclk);
        #1;

        fill(32, -1);
        wr(0, 31, 1, 31);
        drain();
        // INCR write 5..12 with 10..17, read back
        fill(8, 10);
        wr(5, 7, 1, 7);
        rd(5, 7, 1);
        drain();
        // WRAP read across the 4..7 window
        fill(4, 40);
        wr(4, 3, 1, 3);
        rd(6, 3, 2);
        drain();
        // FIXED write then out-of-range INCR write, read both regions back
        fill(3, 1);
        wr(3, 2, 0, 2);
        fill(4, 100);
        wr(30, 3, 1, 3);
        rd(28, 5, 1);
        rd(3, 0, 1);
        drain();
        // back-pressure on both response channels
        b_stall = 2;
        fill(4, -1);
        wr(12, 3, 1, 3);
        rd(8, 7, 1);
        repeat (2) @(posedge aclk);
        r_stall = 3;
        drain();
        // early wlast, missing wlast, illegal bursts
        fill(4, -1);
        wr(16, 3, 1, 1);
        fill(2, -1);
        wr(18, 1, 1, 5);
        fill(3, -1);
        wr(20, 2, 2, 2);
        fill(2, -1);
        wr(24, 1, 3, 1);
        rd(16, 9, 1);
        rd(18, 2, 2);
        rd(0, 3, 3);
        drain();
        // concurrent disjoint write and read
        fill(4, -1);
        fork
            wr(20, 3, 1, 3);
            rd(0, 7, 1);
        join
        drain();
        // reset in the middle of a stalled read
        r_stall = 1000;
        rd(0, 15, 1);
        @(negedge aclk);
        chk("pre_reset_rvalid", rvalid, 1);
        @(posedge aclk);
        #1 reset = 0;
        @(posedge aclk);
        @(negedge aclk);
        chk("abort_outs", {rvalid, arready, awready}, 0);
        rq.delete();
        r_stall = 0;
        @(posedge aclk);
        #1 reset = 1;
        @(posedge aclk);
        @(negedge aclk);
        chk("ready_after_abort", {arready, awready}, 2'b11);
        @(posedge aclk);
        #1;
        rd(0, 31, 1);
        drain();

        rnd = 1;
        for (int n = 0; n < 60; n++) begin
            a   = $urandom_range(0, 40);
            len = $urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : (1 << $urandom_range(0, 4)) - 1;
            bt  = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                lb = $urandom_range(0, 7) == 0 ? $urandom_range(0, len + 1) : len;
                drain();
                fill(len + 1, -1);
                wr(a, len, bt, lb);
            end else rd(a, len, bt);
        end
        drain();
        rnd = 0;
        rd(0, 31, 1);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_burst_mem.md
AXI_BURST_MEM -- requirements
Module: axi_burst_mem

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, data width in bits.
REQ-002 Parameters SHALL be: ADDR_W, 8, word-address width in bits.
REQ-003 Parameters SHALL be: DEPTH, 32, number of memory words (DEPTH <= 2^ADDR_W).
REQ-004 Port aclk SHALL be: input, 1, clock; all logic on rising edge.
REQ-005 Port reset SHALL be: input, 1, reset, synchronous, active-low.
REQ-006 Port awvalid SHALL be: input, 1, write-address valid.
REQ-007 Port awready SHALL be: output, 1, write-address ready.
REQ-008 Port awaddr SHALL be: input, ADDR_W, first-beat word address.
REQ-009 Port awlen SHALL be: input, 8, beats minus one.
REQ-010 Port awburst SHALL be: input, 2, burst type (00 FIXED, 01 INCR, 10 WRAP).
REQ-011 Port wvalid SHALL be: input, 1, write-data valid.
REQ-012 Port wready SHALL be: output, 1, write-data ready.
REQ-013 Port wdata SHALL be: input, DATA_W, write data.
REQ-014 Port wlast SHALL be: input, 1, final write beat.
REQ-015 Port bvalid SHALL be: output, 1, write-response valid.
REQ-016 Port bready SHALL be: input, 1, write-response ready.
REQ-017 Port bresp SHALL be: output, 2, 00 OKAY, 10 SLVERR.
REQ-018 Port arvalid SHALL be: input, 1, read-address valid.
REQ-019 Port arready SHALL be: output, 1, read-address ready.
REQ-020 Port araddr SHALL be: input, ADDR_W, first-beat word address.
REQ-021 Port arlen SHALL be: input, 8, beats minus one.
REQ-022 Port arburst SHALL be: input, 2, burst type.
REQ-023 Port rvalid SHALL be: output, 1, read-data valid.
REQ-024 Port rready SHALL be: input, 1, read-data ready.
REQ-025 Port rdata SHALL be: output, DATA_W, read data.
REQ-026 Port rresp SHALL be: output, 2, per-beat response.
REQ-027 Port rlast SHALL be: output, 1, final read beat.

Function
REQ-028 All outputs SHALL be registered; a transfer occurs only on a cycle with valid && ready both high.
REQ-029 The write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1); transitions: AW handshake -> W_DATA, final beat (beat count == awlen) -> W_RESP, B handshake -> W_IDLE.
REQ-030 Each W beat SHALL write wdata to mem[addr] if addr < DEPTH, otherwise drop it; the first beat is accepted no earlier than the cycle after the AW handshake.
REQ-031 bresp SHALL be SLVERR if any beat was out of range, wlast mismatched the final beat (early or missing), or the burst was illegal; otherwise OKAY. bvalid/bresp SHALL be held stable until bready.
REQ-032 The read FSM SHALL have states R_IDLE (arready=1) and R_DATA (rvalid=1); transitions: AR handshake -> R_DATA, handshake on rlast beat -> R_IDLE.
REQ-033 The first rvalid SHALL assert the cycle after the AR handshake; rdata/rresp/rlast SHALL be held stable while rvalid && !rready; the next beat SHALL be presented the cycle after each handshake.
REQ-034 An out-of-range read beat SHALL return rdata=0 with rresp=SLVERR; in-range beats return OKAY; rlast=1 exactly on beat arlen.
REQ-035 Next address SHALL be: FIXED unchanged; INCR addr+1 modulo 2^ADDR_W; WRAP (addr & ~len) | ((addr+1) & len).
REQ-036 WRAP with len not in {1,3,7,15}, and burst type 11, SHALL be executed as INCR with SLVERR on every beat (read) or in bresp (write).
REQ-037 Read and write channels SHALL operate concurrently; a read of a word written in the same cycle SHALL return the old value.

Reset
REQ-038 While reset=0 at a clock edge, both FSMs SHALL go to IDLE and all outputs SHALL be 0, aborting any burst in progress; awready/arready SHALL rise the first cycle after release.
REQ-039 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-040 Package axi_pkg SHALL hold burst codes FIXED/INCR/WRAP, response codes OKAY/SLVERR, and the write/read state enums.
REQ-041 Next-address logic SHALL be one combinational sub-module axi_burst_addr, instantiated once per channel.

Verification
REQ-042 INCR write awaddr=5, awlen=7, data 10..17, then INCR read araddr=5, awlen=7 -> bresp=OKAY; rdata 10..17; rlast only on 8th beat.
REQ-043 WRAP read araddr=6, arlen=3 after preloading words 4..7 with 40..43 -> rdata 42,43,40,41.
REQ-044 FIXED write addr=3, awlen=2, data 1,2,3 -> mem[3]=3, bresp=OKAY; INCR write addr=30, awlen=3 (DEPTH=32) -> words 30..31 written, bresp=SLVERR.
REQ-045 rready held low 3 cycles mid-burst, bready held low 2 cycles -> rdata/rlast/bvalid/bresp stable, no beat lost or duplicated.
REQ-046 wlast asserted on beat 2 of a 4-beat burst -> bresp=SLVERR; reset=0 mid-read -> rvalid=0 next cycle, arready=1 the cycle after release.
